// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions: tagged code values and the zero-run length.
// Used by the V/B insertion stage, the polarity stage and the decoder.
// Pure definitions; no logic, no latency, no flow control.
package hdb3_pkg;

  // Tagged code stream between insertion and polarity stages.
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_V    = 2'b10;
  localparam logic [1:0] CODE_B    = 2'b11;

  // Zeros per substituted run.
  localparam int HDB3_RUN = 4;

endpackage

// File: rtl/hdb3_vb_insert.sv
// HDB3 V/B insertion: NRZ bits in, tagged codes (zero/one/V/B) out.
// Latency: a bit shows on data_addB after its 4th accepted edge (own included).
// No backpressure; en low freezes every register and drops out_valid.
module hdb3_vb_insert
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       datain,
  output logic [1:0] data_addB,
  output logic       out_valid
);

  // s0 is the newest code, s3 the oldest; s3 drives the output directly.
  logic [1:0] s0, s1, s2, s3;
  logic [1:0] zcnt;
  logic       par;
  logic [2:0] fill;
  logic       subst;

  // Fourth zero of a run: this edge writes V and possibly rewrites the run head.
  assign subst = !datain && (zcnt == 2'(HDB3_RUN - 1));

  // Code shift register, zero-run counter, mark parity and fill tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0        <= CODE_ZERO;
      s1        <= CODE_ZERO;
      s2        <= CODE_ZERO;
      s3        <= CODE_ZERO;
      zcnt      <= 2'd0;
      par       <= 1'b0;
      fill      <= 3'd0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1 <= s0;
      s2 <= s1;
      // With even parity the first zero of the run (leaving s2 now) becomes B.
      s3 <= (subst && !par) ? CODE_B : s2;
      if (datain) begin
        s0   <= CODE_ONE;
        zcnt <= 2'd0;
        par  <= ~par;
      end else if (subst) begin
        // V restarts parity; the B written above therefore never counts.
        s0   <= CODE_V;
        zcnt <= 2'd0;
        par  <= 1'b0;
      end else begin
        s0   <= CODE_ZERO;
        zcnt <= zcnt + 2'd1;
      end
      if (fill != 3'(HDB3_RUN)) begin
        fill <= fill + 3'd1;
      end
      // Valid once the pipe holds real codes in all four stages.
      out_valid <= (fill >= 3'(HDB3_RUN - 1));
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign data_addB = s3;

endmodule

// File: tb/tb_hdb3_vb_insert.sv
// Testbench for hdb3_vb_insert: table vectors, hand sequences and a random run.
// Expected codes are queued as bits are driven and popped on out_valid.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hdb3_vb_insert;
  import hdb3_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       datain = 1'b0;
  logic [1:0] data_addB;
  logic       out_valid;

  int errors = 0;
  int checks = 0;
  int accepts = 0;

  logic [1:0] exp_q[$];
  int         m_zcnt = 0;
  logic       m_par = 1'b0;

  typedef struct {
    logic [7:0]  bits;   // bit i sent is bits[7-i]
    int          n;
    logic [15:0] codes;  // expected code i is codes[15-2*i -: 2]
    int          gap;    // en-low cycles after every bit
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  hdb3_vb_insert dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .datain    (datain),
    .data_addB (data_addB),
    .out_valid (out_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference encoder: edits the queued code three entries back when B is due.
  task automatic model_bit(input logic b);
    if (b) begin
      exp_q.push_back(CODE_ONE);
      m_zcnt = 0;
      m_par  = ~m_par;
    end else if (m_zcnt < 3) begin
      exp_q.push_back(CODE_ZERO);
      m_zcnt++;
    end else begin
      if (!m_par) exp_q[exp_q.size() - 3] = CODE_B;
      exp_q.push_back(CODE_V);
      m_zcnt = 0;
      m_par  = 1'b0;
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, sample.
  task automatic step(input logic e, input logic d);
    logic [1:0] prev;
    prev   = data_addB;
    en     = e;
    datain = d;
    @(negedge clk);
    if (e) begin
      accepts++;
      check("out_valid_fill", out_valid, accepts >= 4);
    end else begin
      check("out_valid_hold", out_valid, 1'b0);
      check("data_hold", data_addB, prev);
    end
    if (out_valid && exp_q.size() > 0) begin
      check("code", data_addB, exp_q.pop_front());
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    accepts = 0;
    m_zcnt  = 0;
    m_par   = 1'b0;
  endtask

  task automatic do_reset();
    en     = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("reset_data", data_addB, 2'b00);
    check("reset_valid", out_valid, 1'b0);
    reset = 1'b0;
    clear_model();
  endtask

  // Push trailing ones until every queued code has been seen.
  task automatic flush();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 12) begin
      step(1'b1, 1'b1);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout: %0d codes still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hFF,        8, {8{2'b01}}, 0};
    tbl[1] = '{8'b0000_0000, 4, {2'b11, 2'b00, 2'b00, 2'b10, 8'h00}, 0};
    tbl[2] = '{8'b1000_0000, 5, {2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 6'b0}, 0};
    tbl[3] = '{8'b0000_0000, 8, {2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10}, 0};
    tbl[4] = '{8'b1100_0000, 6, {2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 4'b0}, 0};
    tbl[5] = '{8'b1000_0000, 5, {2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 6'b0}, 2};
    tbl[6] = '{8'b1110_0000, 7, {2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b0}, 0};

    #1;
    check("init_data", data_addB, 2'b00);
    check("init_valid", out_valid, 1'b0);
    @(negedge clk);

    // Table vectors with hand-derived code sequences.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      for (int i = 0; i < tbl[t].n; i++) begin
        exp_q.push_back(tbl[t].codes[15 - 2 * i -: 2]);
        step(1'b1, tbl[t].bits[7 - i]);
        for (int g = 0; g < tbl[t].gap; g++) step(1'b0, 1'b0);
      end
      flush();
    end

    // Reset with three zeros pending: queued codes and the zero count vanish.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      model_bit(1'b0);
      step(1'b1, 1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    check("midreset_data", data_addB, 2'b00);
    check("midreset_valid", out_valid, 1'b0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(CODE_B);
    exp_q.push_back(CODE_ZERO);
    exp_q.push_back(CODE_ZERO);
    exp_q.push_back(CODE_V);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    flush();

    // Random zero-heavy stream with occasional en-low cycles.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      logic b;
      b = ($urandom_range(0, 3) == 0);
      model_bit(b);
      step(1'b1, b);
      if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0);
    end
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
